// File: rtl/fir_filter_pkg.sv
// Shared types and elaboration-time sizing helpers for the fir_filter datapath.
// Holds the symmetry encoding and the default 37-tap symmetric coefficient set.
package fir_filter_pkg;

  typedef enum int {
    NON_SYM  = 0,
    SYM      = 1,
    ANTI_SYM = 2
  } symmetry_e;

  // Number of multiplier products after symmetric folding.
  function automatic int calc_num_products(int num_taps, int symmetry);
    if (symmetry == int'(SYM))      return (num_taps + 1) / 2;
    if (symmetry == int'(ANTI_SYM)) return num_taps / 2;
    return num_taps;
  endfunction

  function automatic int calc_tree_depth(int num_in);
    return (num_in <= 1) ? 0 : $clog2(num_in);
  endfunction

  function automatic int calc_full_width(int input_width, int coeff_width, int num_taps);
    return input_width + coeff_width + 1 + $clog2(num_taps);
  endfunction

  // Operand count entering adder-tree level (level+1); odd operands pass through.
  function automatic int calc_level_count(int num_in, int level);
    int n;
    n = num_in;
    for (int l = 0; l < level; l++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic bit is_level_registered(int level, int ratio);
    return (ratio != 0) && (level % ratio == 0);
  endfunction

  function automatic int calc_tree_regs(int depth, int ratio);
    return (ratio == 0) ? 0 : depth / ratio;
  endfunction

  function automatic int calc_latency(int symmetry, int pipe_mul, int depth,
                                      int ratio, int out_reg);
    return 1 + ((symmetry != int'(NON_SYM)) ? 1 : 0) + pipe_mul
             + calc_tree_regs(depth, ratio) + out_reg;
  endfunction

  localparam logic signed [7:0] DEFAULT_COEFFS [0:36] = '{
    8'sd8,   8'sd2,   -8'sd3,  -8'sd5,  -8'sd4,  8'sd0,   8'sd5,   8'sd8,
    8'sd7,   8'sd2,   -8'sd6,  -8'sd10, -8'sd8,  8'sd3,   8'sd20,  8'sd42,
    8'sd63,  8'sd70,  8'sd127, 8'sd70,  8'sd63,  8'sd42,  8'sd20,  8'sd3,
    -8'sd8,  -8'sd10, -8'sd6,  8'sd2,   8'sd7,   8'sd8,   8'sd5,   8'sd0,
    -8'sd4,  -8'sd5,  -8'sd3,  8'sd2,   8'sd8
  };

endpackage

// File: rtl/fir_filter_adder_tree.sv
// Parameterised NUM_IN-input signed binary adder tree; level l is registered
// when RATIO != 0 and l % RATIO == 0, odd operands pass straight through.
module fir_adder_tree
  import fir_filter_pkg::*;
#(
  parameter int NUM_IN = 19,
  parameter int WIDTH  = 31,
  parameter int RATIO  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic signed [WIDTH-1:0] i_data [0:NUM_IN-1],
  output logic signed [WIDTH-1:0] o_sum
);

  localparam int DEPTH = calc_tree_depth(NUM_IN);

  logic signed [WIDTH-1:0] w_sum [0:DEPTH][0:NUM_IN-1];
  logic signed [WIDTH-1:0] r_sum [0:DEPTH][0:NUM_IN-1];
  logic signed [WIDTH-1:0] w_root;

  always_comb begin
    logic signed [WIDTH-1:0] v_cur [0:NUM_IN-1];
    int                      v_n;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    for (int l = 0; l <= DEPTH; l++)
      for (int j = 0; j < NUM_IN; j++) w_sum[l][j] = '0;
    v_cur = i_data;
    for (int l = 1; l <= DEPTH; l++) begin
      v_n = calc_level_count(NUM_IN, l - 1);
      for (int j = 0; j < v_n / 2; j++) w_sum[l][j] = v_cur[2*j] + v_cur[2*j+1];
      if (v_n % 2 == 1) w_sum[l][v_n/2] = v_cur[v_n-1];
      v_cur = is_level_registered(l, RATIO) ? r_sum[l] : w_sum[l];
    end
    w_root = v_cur[0];
  end

  // Unregistered levels keep constant-zero copies that synthesis removes.
  always_ff @(posedge i_clk) begin
    for (int l = 0; l <= DEPTH; l++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (i_rst || !is_level_registered(l, RATIO) || l == 0) r_sum[l][j] <= '0;
        else                                                   r_sum[l][j] <= w_sum[l][j];
      end
    end
  end

  assign o_sum = w_root;

endmodule

// File: rtl/fir_filter.sv
// Fully parallel direct-form FIR with optional symmetric pre-add and configurable pipelining.
// Define FIR_PARAM_CHECK_EN to enable elaboration-time parameter/coefficient checks.
module fir_filter
  import fir_filter_pkg::*;
#(
  parameter int INPUT_WIDTH        = 16,
  parameter int COEFF_WIDTH        = 8,
  parameter int OUTPUT_WIDTH       = 26,
  parameter int SYMMETRY           = 1,
  parameter int NUM_TAPS           = 37,
  parameter logic signed [COEFF_WIDTH-1:0] COEFFS [0:NUM_TAPS-1] = DEFAULT_COEFFS,
  parameter int PIPELINE_MUL       = 1,
  parameter int PIPELINE_ADD_RATIO = 1,
  parameter int OUTPUT_REG         = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid_in,
  input  logic signed [INPUT_WIDTH-1:0]  i_din,
  output logic                           o_valid_out,
  output logic signed [OUTPUT_WIDTH-1:0] o_dout
);

  localparam int M  = calc_num_products(NUM_TAPS, SYMMETRY);
  localparam int D  = calc_tree_depth(M);
  localparam int FW = calc_full_width(INPUT_WIDTH, COEFF_WIDTH, NUM_TAPS);
  localparam int PW = INPUT_WIDTH + 1;
  localparam int L  = calc_latency(SYMMETRY, PIPELINE_MUL, D, PIPELINE_ADD_RATIO, OUTPUT_REG);

  logic signed [INPUT_WIDTH-1:0] r_x [0:NUM_TAPS-1];

  // NOTE: the delay line is reset like any register so a reset discards in-flight samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_TAPS; k++) r_x[k] <= '0;
    end else if (i_valid_in) begin
      // NOTE: non-blocking so each tap takes its neighbour's pre-edge value.
      r_x[0] <= i_din;
      for (int k = 1; k < NUM_TAPS; k++) r_x[k] <= r_x[k-1];
    end
  end

  logic signed [PW-1:0] w_pre [0:M-1];
  logic signed [PW-1:0] w_tap [0:M-1];

  always_comb begin
    for (int k = 0; k < M; k++) begin
      if (SYMMETRY == int'(NON_SYM) || k >= NUM_TAPS / 2)
        w_pre[k] = PW'(r_x[k]);  // also the odd-length symmetric centre tap
      else if (SYMMETRY == int'(SYM))
        w_pre[k] = PW'(r_x[k]) + PW'(r_x[NUM_TAPS-1-k]);
      else
        w_pre[k] = PW'(r_x[k]) - PW'(r_x[NUM_TAPS-1-k]);
    end
  end

  if (SYMMETRY != int'(NON_SYM)) begin : g_pre_reg
    logic signed [PW-1:0] r_pre [0:M-1];
    always_ff @(posedge i_clk) begin
      for (int k = 0; k < M; k++) r_pre[k] <= i_rst ? '0 : w_pre[k];
    end
    assign w_tap = r_pre;
  end else begin : g_pre_comb
    assign w_tap = w_pre;
  end

  logic signed [FW-1:0] w_prod [0:M-1];
  logic signed [FW-1:0] w_mul  [0:M-1];

  always_comb begin
    for (int k = 0; k < M; k++) w_prod[k] = FW'(w_tap[k]) * FW'(COEFFS[k]);
  end

  if (PIPELINE_MUL != 0) begin : g_mul_reg
    logic signed [FW-1:0] r_prod [0:M-1];
    always_ff @(posedge i_clk) begin
      for (int k = 0; k < M; k++) r_prod[k] <= i_rst ? '0 : w_prod[k];
    end
    assign w_mul = r_prod;
  end else begin : g_mul_comb
    assign w_mul = w_prod;
  end

  logic signed [FW-1:0] w_sum;

  fir_adder_tree #(
    .NUM_IN (M),
    .WIDTH  (FW),
    .RATIO  (PIPELINE_ADD_RATIO)
  ) u_tree (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (w_mul),
    .o_sum  (w_sum)
  );

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic signed [OUTPUT_WIDTH-1:0] r_dout;
    always_ff @(posedge i_clk) begin
      r_dout <= i_rst ? '0 : w_sum[OUTPUT_WIDTH-1:0];
    end
    assign o_dout = r_dout;
  end else begin : g_out_comb
    assign o_dout = w_sum[OUTPUT_WIDTH-1:0];
  end

  logic [L-1:0] r_vpipe;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0] <= i_valid_in;
      for (int k = 1; k < L; k++) r_vpipe[k] <= r_vpipe[k-1];
    end
  end

  assign o_valid_out = r_vpipe[L-1];

`ifdef FIR_PARAM_CHECK_EN
  function automatic bit coeffs_match_symmetry();
    for (int k = 0; k < NUM_TAPS / 2; k++) begin
      if (SYMMETRY == int'(SYM) && COEFFS[k] != COEFFS[NUM_TAPS-1-k]) return 1'b0;
      if (SYMMETRY == int'(ANTI_SYM) && COEFFS[k] != -COEFFS[NUM_TAPS-1-k]) return 1'b0;
    end
    if (SYMMETRY == int'(ANTI_SYM) && NUM_TAPS % 2 == 1 && COEFFS[NUM_TAPS/2] != '0)
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint coeff_abs_sum();
    longint s;
    s = 0;
    for (int k = 0; k < NUM_TAPS; k++)
      s += (COEFFS[k] < 0) ? -longint'(COEFFS[k]) : longint'(COEFFS[k]);
    return s;
  endfunction

  if (SYMMETRY < 0 || SYMMETRY > 2) begin : g_chk_sym
    $error("fir_filter: SYMMETRY must be 0, 1 or 2");
  end
  if (NUM_TAPS < 2) begin : g_chk_taps
    $error("fir_filter: NUM_TAPS must be at least 2");
  end
  if (!coeffs_match_symmetry()) begin : g_chk_coeffs
    $error("fir_filter: COEFFS do not match SYMMETRY");
  end
  if (coeff_abs_sum() * (longint'(1) << (INPUT_WIDTH - 1)) >
      (longint'(1) << (OUTPUT_WIDTH - 1)) - 1) begin : g_chk_range
    $error("fir_filter: worst-case output does not fit OUTPUT_WIDTH");
  end
`endif

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter: default build plus two swept parameter sets
// checked against a direct-convolution model kept in the bench.
`timescale 1ns/1ps
module tb_fir_filter;

  localparam int OW    = 26;
  localparam int L_DEF = 9;  // delay line + pre-add + multiply + 5 tree levels + output
  localparam int L_S0  = 2;  // delay line + multiply; tree and output combinational
  localparam int L_S2  = 4;  // delay line + pre-add + tree levels 2 and 4

  localparam int DEF_C [0:36] = '{
    8, 2, -3, -5, -4, 0, 5, 8, 7, 2, -6, -10, -8, 3, 20, 42, 63, 70, 127,
    70, 63, 42, 20, 3, -8, -10, -6, 2, 7, 8, 5, 0, -4, -5, -3, 2, 8
  };

  localparam logic signed [7:0] S0_C [0:35] = '{
    8'sd3,   -8'sd7,  8'sd12,  -8'sd20, 8'sd31,  -8'sd45, 8'sd60,  -8'sd77, 8'sd100,
    8'sd127, -8'sd127, 8'sd90, -8'sd64, 8'sd40,  -8'sd25, 8'sd15,  -8'sd9,  8'sd5,
    8'sd1,   8'sd2,   8'sd4,   8'sd8,   8'sd16,  8'sd32,  8'sd64,  -8'sd1,  -8'sd2,
    -8'sd4,  -8'sd8,  -8'sd16, -8'sd32, -8'sd64, 8'sd11,  -8'sd13, 8'sd17,  -8'sd19
  };

  localparam logic signed [7:0] S2_C [0:35] = '{
    8'sd9,   -8'sd14, 8'sd22,  -8'sd30, 8'sd41,  -8'sd55, 8'sd70,  -8'sd88, 8'sd110,
    8'sd127, -8'sd100, 8'sd75, -8'sd50, 8'sd33,  -8'sd21, 8'sd13,  -8'sd6,  8'sd2,
    -8'sd2,  8'sd6,   -8'sd13, 8'sd21,  -8'sd33, 8'sd50,  -8'sd75, 8'sd100, -8'sd127,
    -8'sd110, 8'sd88, -8'sd70, 8'sd55,  -8'sd41, 8'sd30,  -8'sd22, 8'sd14,  -8'sd9
  };

  logic               clk   = 1'b0;
  logic               rst   = 1'b1;
  logic               valid = 1'b0;
  logic signed [15:0] din   = '0;

  logic          v_def, v_s0, v_s2;
  logic [OW-1:0] d_def, d_s0, d_s2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fir_filter u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid_in(valid), .i_din(din),
    .o_valid_out(v_def), .o_dout(d_def)
  );

  fir_filter #(
    .SYMMETRY(0), .NUM_TAPS(36), .COEFFS(S0_C),
    .PIPELINE_MUL(1), .PIPELINE_ADD_RATIO(0), .OUTPUT_REG(0)
  ) u_sw0 (
    .i_clk(clk), .i_rst(rst), .i_valid_in(valid), .i_din(din),
    .o_valid_out(v_s0), .o_dout(d_s0)
  );

  fir_filter #(
    .SYMMETRY(2), .NUM_TAPS(36), .COEFFS(S2_C),
    .PIPELINE_MUL(0), .PIPELINE_ADD_RATIO(2), .OUTPUT_REG(0)
  ) u_sw2 (
    .i_clk(clk), .i_rst(rst), .i_valid_in(valid), .i_din(din),
    .o_valid_out(v_s2), .o_dout(d_s2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; din = '0;
    repeat (10) tick();
    n_checks++;
    if (d_def !== '0 || v_def !== 1'b0)
      $display("FAIL reset_def: dout=%h valid=%b, want 0/0", d_def, v_def);
    else n_pass++;
    n_checks++;
    if (d_s0 !== '0 || v_s0 !== 1'b0 || d_s2 !== '0 || v_s2 !== 1'b0)
      $display("FAIL reset_sweep: s0=%h/%b s2=%h/%b, want 0/0", d_s0, v_s0, d_s2, v_s2);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    logic [OW-1:0] exp_d;
    int            k;
    for (int n = 0; n < 37 + L_DEF; n++) begin
      valid = 1'b1;
      din   = (n == 0) ? 16'sh8000 : 16'sh0000;
      tick();
      if (n < L_DEF - 1) begin
        n_checks++;
        if (v_def !== 1'b0 || d_def !== '0)
          $display("FAIL impulse_pre n=%0d: dout=%h valid=%b, want 0/0", n, d_def, v_def);
        else n_pass++;
      end else begin
        k     = n - (L_DEF - 1);
        exp_d = (k < 37) ? OW'(-32768 * DEF_C[k]) : '0;
        n_checks++;
        if (v_def !== 1'b1 || d_def !== exp_d)
          $display("FAIL impulse k=%0d: dout=%h valid=%b, want %h/1", k, d_def, v_def, exp_d);
        else n_pass++;
        if (k == 0) begin
          n_checks++;
          if (d_def !== 26'h3FC0000) $display("FAIL impulse_first: dout=%h want 3fc0000", d_def);
          else n_pass++;
        end
        if (k == 18) begin
          n_checks++;
          if (d_def !== 26'h3C08000) $display("FAIL impulse_peak: dout=%h want 3c08000", d_def);
          else n_pass++;
        end
      end
    end
    valid = 1'b0;
    din   = '0;
  endtask

  task automatic test_step();
    for (int n = 0; n < 37; n++) begin
      valid = 1'b1; din = 16'sh8000;
      tick();
    end
    valid = 1'b0; din = '0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (n >= L_DEF - 2) begin
        n_checks++;
        if (d_def !== 26'h2FE8000 || v_def !== (n == L_DEF - 2))
          $display("FAIL step_hold n=%0d: dout=%h valid=%b, want 2fe8000/%b",
                   n, d_def, v_def, (n == L_DEF - 2));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_step();
    for (int n = 0; n < 15; n++) begin
      valid = 1'b1; din = 16'sh8000;
      tick();
    end
    rst = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      n_checks++;
      if (d_def !== '0 || v_def !== 1'b0 || d_s0 !== '0 || d_s2 !== '0)
        $display("FAIL midrst n=%0d: dout=%h valid=%b s0=%h s2=%h, want 0", n, d_def, v_def, d_s0, d_s2);
      else n_pass++;
    end
    rst = 1'b0; valid = 1'b0; din = '0;
    for (int n = 0; n < 200; n++) begin
      tick();
      n_checks++;
      if (d_def !== '0 || v_def !== 1'b0)
        $display("FAIL midrst_idle n=%0d: dout=%h valid=%b, want 0/0", n, d_def, v_def);
      else n_pass++;
    end
  endtask

  task automatic test_gap();
    logic [OW-1:0] exp_d;
    logic          exp_v;
    int            m;
    for (int n = 0; n <= 80 + L_DEF - 1; n++) begin
      valid = (n % 2 == 0) && (n < 80);
      din   = (n == 0) ? 16'sh8000 : 16'sh0000;
      tick();
      if (n < L_DEF - 1) begin
        exp_v = 1'b0; exp_d = '0;
      end else begin
        m     = n - (L_DEF - 1);
        exp_v = (m % 2 == 0) && (m < 80);
        exp_d = (m / 2 < 37) ? OW'(-32768 * DEF_C[m/2]) : '0;
      end
      n_checks++;
      if (d_def !== exp_d || v_def !== exp_v)
        $display("FAIL gap n=%0d: dout=%h valid=%b, want %h/%b", n, d_def, v_def, exp_d, exp_v);
      else n_pass++;
    end
    valid = 1'b0;
    din   = '0;
  endtask

  task automatic test_param_sweep();
    int            xm [0:35];
    logic [OW-1:0] yh0 [$];
    logic [OW-1:0] yh2 [$];
    logic          vh  [$];
    int            acc0, acc2, i0, i2;
    logic [OW-1:0] e0, e2;
    logic          ev0, ev2;
    for (int k = 0; k < 36; k++) xm[k] = 0;
    rst = 1'b1; valid = 1'b0; din = '0;
    repeat (4) tick();
    rst = 1'b0;
    for (int n = 0; n < 120; n++) begin
      valid = (n < 100) && (n % 3 != 2);
      din   = (n < 40) ? 16'(n * 12345 + 777) : (n < 70) ? 16'sh8000 : 16'sh7FFF;
      tick();
      if (valid) begin
        for (int k = 35; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = int'(din);
      end
      acc0 = 0; acc2 = 0;
      for (int k = 0; k < 36; k++) begin
        acc0 += int'(S0_C[k]) * xm[k];
        acc2 += int'(S2_C[k]) * xm[k];
      end
      yh0.push_back(OW'(acc0));
      yh2.push_back(OW'(acc2));
      vh.push_back(valid);
      i0  = n - (L_S0 - 1);
      i2  = n - (L_S2 - 1);
      e0  = (i0 < 0) ? '0 : yh0[i0];
      ev0 = (i0 < 0) ? 1'b0 : vh[i0];
      e2  = (i2 < 0) ? '0 : yh2[i2];
      ev2 = (i2 < 0) ? 1'b0 : vh[i2];
      n_checks++;
      if (d_s0 !== e0 || v_s0 !== ev0)
        $display("FAIL sweep_sym0 n=%0d: dout=%h valid=%b, want %h/%b", n, d_s0, v_s0, e0, ev0);
      else n_pass++;
      n_checks++;
      if (d_s2 !== e2 || v_s2 !== ev2)
        $display("FAIL sweep_sym2 n=%0d: dout=%h valid=%b, want %h/%b", n, d_s2, v_s2, e2, ev2);
      else n_pass++;
    end
    valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_reset_mid_step();
    test_gap();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
